crc_lut_builder: RTL
====================

Name: crc_lut_builder

Overview:
- Runtime-programmable successor to the fixed per-stage CRC lookup tables used by the pipelined LUT CRC engine.
- Computes a 256-entry CRC stage table in hardware from a programmable polynomial, CRC width and stage index, then serves registered lookups.
- One instance can stand in for any fixed stage table, and it can be rebuilt for a new polynomial without re-synthesis.
- Entry definition: T_k[i] = (i(x) · x^(CRC_WIDTH + 8·k)) mod P(x), MSB-first, init 0, no final XOR.

Parameters:
- CRC_WIDTH, 32, CRC/polynomial width in bits (8..32); also the table entry width.
- STAGE_BITS, 5, width of cfg_stage; k ranges 0..2^STAGE_BITS-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_poly  in  CRC_WIDTH  polynomial in normal form, implicit x^CRC_WIDTH term omitted (CRC-32 = 0x04C11DB7).
- cfg_stage  in  STAGE_BITS  stage index k: number of trailing zero bytes folded into the table.
- start  in  1  build request; sampled only when busy=0.
- busy  out  1  build in progress.
- ready  out  1  table contents valid for cfg latched at the last start.
- rd_en  in  1  lookup request.
- addr  in  32  lookup address; only addr[7:0] is used.
- rdata  out  CRC_WIDTH  registered lookup data.
- rvalid  out  1  rdata valid, one cycle after rd_en.
- rd_miss  out  1  qualifies rvalid; set when the lookup was issued while ready=0.

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; busy=0, ready=0, rvalid=0, rd_miss=0, rdata=0; basis and counters cleared; table RAM contents undefined.
- start accepted (start=1, busy=0): latch cfg_poly and cfg_stage; ready<=0 and busy<=1 on the same edge; r<=1 (x^0), n<=0; go to POWER.
- start while busy=1: ignored. cfg_* changes after acceptance have no effect.
- POWER state:
  - Each cycle: r <= (r<<1) ^ (r[MSB] ? poly : 0), truncated to CRC_WIDTH; n++.
  - After N = CRC_WIDTH + 8·k cycles, r = x^N mod P; go to CAPTURE.
- CAPTURE state:
  - 8 cycles, j = 0..7: basis[j] <= r, then r advances as in POWER.
  - Result: basis[j] = x^(N+j) mod P.
- FILL state:
  - 256 cycles, i = 0..255: mem[i] <= XOR of basis[j] over every set bit j of i; mem[0] = 0.
  - One write per cycle.
- DONE: on the edge after the last write, busy<=0, ready<=1; return to IDLE.
- Build time: busy is high for exactly N + 264 cycles. CRC-32 with k=0 gives 296 cycles.
- Lookups:
  - rd_en sampled on an edge → next cycle rvalid=1 and rdata=mem[addr[7:0]].
  - If ready=0 at sampling, rdata=0 and rd_miss=1.
  - rvalid=0 and rd_miss=0 in cycles with no request; rdata holds its last value.
  - Back-to-back lookups are allowed every cycle. A read and a FILL write never conflict because reads are masked to 0 while ready=0.
- Rebuild while ready=1: ready drops on the start edge. Lookups from that edge until the new ready return rd_miss=1.
- Reset mid-build: abort immediately; ready=0 until a full new build completes.
- CRC_WIDTH<32: the upper bits of rdata, if any, are not present. All arithmetic is modulo 2 at CRC_WIDTH bits.

Optional Feature:
- Macro: CRC_LUT_REFLECT_EN.
- Defined:
  - Adds input cfg_reflect (1 bit), latched on start.
  - When the latched cfg_reflect=1, FILL writes mem[i] = bitrev_W(T_k[bitrev8(i)]), giving the LSB-first (reflected) table. cfg_poly stays in normal form.
  - Build time is unchanged.
- Undefined:
  - No cfg_reflect port; the table is always MSB-first.

Test Plan:
1. CRC-32 normal table: poly=0x04C11DB7, stage=0, start → busy high 296 cycles, then ready=1. Lookups return addr 0x01→0x04C11DB7, 0x02→0x09823B6E, 0x80→0x690CE0EE, 0xFF→0xB1F740B4, 0x00→0.
2. Stage index: stage=17 with the same poly → busy high 32+136+264=432 cycles. Every entry equals a software model of x^(32+136)·i mod P, and entries obey T[a^b]=T[a]^T[b] for all a, b.
3. Miss and latency: rd_en on each cycle during a build → rvalid=1 with rd_miss=1 and rdata=0 one cycle later. After ready, rd_en with addr=0xABCD0001 → rdata=T[0x01], rd_miss=0.
4. Control corners:
   - start pulsed mid-build → ignored; the first table completes.
   - start with ready=1 → ready=0 on the next cycle, and the new poly table is valid after rebuild.
   - rstn low mid-FILL → all outputs 0 asynchronously.
5. CRC_WIDTH=16, poly=0x1021, stage=0 → T[0x01]=0x1021, T[0xFF]=0x1EF0, matching the CRC-16/XMODEM table.
6. With CRC_LUT_REFLECT_EN, cfg_reflect=1, poly=0x04C11DB7 → T[0x01]=0x77073096, T[0x80]=0xEDB88320, T[0xFF]=0x2D02EF8D.

Source files
------------

// File: rtl/crc_lut_builder.sv
// crc_lut_builder: builds a 256-entry CRC stage table T_k[i] = i(x)*x^(W+8k) mod P(x)
// from a runtime polynomial and stage index, then serves registered lookups.
// The table is built in three phases: POWER (compute x^N mod P), CAPTURE (the eight
// basis values x^(N+j) mod P) and FILL (one table write per cycle, each entry the XOR of
// the basis values selected by its index bits).
// Optional macro CRC_LUT_REFLECT_EN adds cfg_reflect for LSB-first (reflected) tables.
module crc_lut_builder #(
  parameter int CRC_WIDTH  = 32,
  parameter int STAGE_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CRC_WIDTH-1:0]  cfg_poly,
  input  logic [STAGE_BITS-1:0] cfg_stage,
`ifdef CRC_LUT_REFLECT_EN
  input  logic                  cfg_reflect,
`endif
  input  logic                  start,
  output logic                  busy,
  output logic                  ready,
  input  logic                  rd_en,
  input  logic [31:0]           addr,
  output logic [CRC_WIDTH-1:0]  rdata,
  output logic                  rvalid,
  output logic                  rd_miss
);

  // Counter wide enough for the longest power run N = CRC_WIDTH + 8*(2^STAGE_BITS - 1).
  localparam int CW = $clog2(CRC_WIDTH + 8 * (2 ** STAGE_BITS)) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POWER   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FILL    = 2'd3
  } state_t;

  state_t                r_state;
  logic [CRC_WIDTH-1:0]  r_poly;
  logic [STAGE_BITS-1:0] r_stage;
  logic [CRC_WIDTH-1:0]  r_pow;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            r_idx;
  logic [CRC_WIDTH-1:0]  r_basis [8];
  logic [CRC_WIDTH-1:0]  r_mem [256];
`ifdef CRC_LUT_REFLECT_EN
  logic                  r_reflect;
`endif

  logic [CW-1:0]         w_n_last;
  logic [CRC_WIDTH-1:0]  w_pow_next;
  logic [7:0]            w_fill_sel;
  logic [CRC_WIDTH-1:0]  w_fill_raw;
  logic [CRC_WIDTH-1:0]  w_fill_data;
  logic                  w_unused_addr;

  // Multiply by x modulo P(x), MSB-first, truncated to CRC_WIDTH bits.
  function automatic logic [CRC_WIDTH-1:0] f_mulx(input logic [CRC_WIDTH-1:0] v,
                                                  input logic [CRC_WIDTH-1:0] p);
    f_mulx = {v[CRC_WIDTH-2:0], 1'b0} ^ (v[CRC_WIDTH-1] ? p : {CRC_WIDTH{1'b0}});
  endfunction

`ifdef CRC_LUT_REFLECT_EN
  function automatic logic [7:0] f_rev8(input logic [7:0] v);
    for (int b = 0; b < 8; b++) begin
      f_rev8[b] = v[7-b];
    end
  endfunction

  function automatic logic [CRC_WIDTH-1:0] f_revw(input logic [CRC_WIDTH-1:0] v);
    for (int b = 0; b < CRC_WIDTH; b++) begin
      f_revw[b] = v[CRC_WIDTH-1-b];
    end
  endfunction
`endif

  // Only the low address byte selects an entry.
  assign w_unused_addr = ^addr[31:8];

  // Last POWER count (N-1) and the next power-of-x value.
  always_comb begin
    w_n_last   = CW'(CRC_WIDTH) + CW'({r_stage, 3'b000}) - CW'(1);
    w_pow_next = f_mulx(r_pow, r_poly);
  end

  // Table entry for the current FILL index: XOR of basis values picked by index bits.
  always_comb begin
    w_fill_sel = r_idx;
`ifdef CRC_LUT_REFLECT_EN
    if (r_reflect) begin
      w_fill_sel = f_rev8(r_idx);
    end else begin
      w_fill_sel = r_idx;
    end
`endif
    w_fill_raw = {CRC_WIDTH{1'b0}};
    for (int j = 0; j < 8; j++) begin
      if (w_fill_sel[j]) begin
        w_fill_raw = w_fill_raw ^ r_basis[j];
      end else begin
        w_fill_raw = w_fill_raw;
      end
    end
    w_fill_data = w_fill_raw;
`ifdef CRC_LUT_REFLECT_EN
    if (r_reflect) begin
      w_fill_data = f_revw(w_fill_raw);
    end else begin
      w_fill_data = w_fill_raw;
    end
`endif
  end

  // Build sequencer: config latch, power run, basis capture, table fill, status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      ready   <= 1'b0;
      r_poly  <= {CRC_WIDTH{1'b0}};
      r_stage <= {STAGE_BITS{1'b0}};
      r_pow   <= {CRC_WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_idx   <= 8'd0;
`ifdef CRC_LUT_REFLECT_EN
      r_reflect <= 1'b0;
`endif
      for (int j = 0; j < 8; j++) begin
        r_basis[j] <= {CRC_WIDTH{1'b0}};
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_poly  <= cfg_poly;
            r_stage <= cfg_stage;
`ifdef CRC_LUT_REFLECT_EN
            r_reflect <= cfg_reflect;
`endif
            ready   <= 1'b0;
            busy    <= 1'b1;
            r_pow   <= {{(CRC_WIDTH-1){1'b0}}, 1'b1};
            r_cnt   <= {CW{1'b0}};
            r_idx   <= 8'd0;
            r_state <= ST_POWER;
          end
        end
        ST_POWER: begin
          r_pow <= w_pow_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == w_n_last) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_basis[r_idx[2:0]] <= r_pow;
          r_pow               <= w_pow_next;
          if (r_idx[2:0] == 3'd7) begin
            r_idx   <= 8'd0;
            r_state <= ST_FILL;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end
        ST_FILL: begin
          r_idx <= r_idx + 8'd1;
          // The last write and the busy->ready handover share one edge.
          if (r_idx == 8'd255) begin
            busy    <= 1'b0;
            ready   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          ready   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Table RAM: one write per FILL cycle, no reset (contents qualified by ready).
  always_ff @(posedge clk) begin
    if (r_state == ST_FILL) begin
      r_mem[r_idx] <= w_fill_data;
    end
  end

  // Registered lookup port; lookups while the table is not ready return 0 with rd_miss.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata   <= {CRC_WIDTH{1'b0}};
      rvalid  <= 1'b0;
      rd_miss <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        if (ready) begin
          rdata   <= r_mem[addr[7:0]];
          rd_miss <= 1'b0;
        end else begin
          rdata   <= {CRC_WIDTH{1'b0}};
          rd_miss <= 1'b1;
        end
      end else begin
        rd_miss <= 1'b0;
      end
    end
  end

endmodule
